count_display: RTL

Downstream consumer of the 8-bit free-running counter value bus. It detects changes on the bus and converts the binary value to three BCD digits using a sequential shift-add-3 (double-dabble) engine. It then drives a 3-digit time-multiplexed, active-low seven-segment display. It sits between the counter and the board display pins.

---
 rtl/count_display.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/count_display.sv
// ============================================================================
// Module      : count_display
// Description : Converts an 8-bit count to BCD with a sequential double-dabble
//               engine and drives a 3-digit multiplexed active-low display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_display #(
    parameter int REFRESH_DIV   = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_CONV = 1'b1;

    localparam int              c_RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_RW-1:0] c_REF_MAX = c_RW'(REFRESH_DIV - 1);

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;

    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic [7:0]      r_last;
    logic [7:0]      r_src;
    logic [11:0]     r_scr;
    logic [2:0]      r_cnt;
    logic [11:0]     r_bcd;
    logic [c_RW-1:0] r_ref;
    logic [1:0]      r_idx;

    logic            w_capture;
    logic            w_last_shift;
    logic [7:0]      w_lo_adj;
    logic [2:0]      w_hi_adj;
    logic [11:0]     w_scr_next;
    logic            w_ref_wrap;
    logic [3:0]      w_digit;
    logic            w_blank;

    assign w_capture    = (r_state == c_IDLE) && (value != r_last);
    assign w_last_shift = (r_state == c_CONV) && (r_cnt == 3'd7);
    assign w_ref_wrap   = (r_ref == c_REF_MAX);

    // Add-3 correction on the ones and tens digits before each shift.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_adj
            assign w_lo_adj[gi*4 +: 4] = (r_scr[gi*4 +: 4] >= 4'd5) ?
                                         (r_scr[gi*4 +: 4] + 4'd3) : r_scr[gi*4 +: 4];
        end
    endgenerate

    // The hundreds MSB is shifted out, so only its low three bits survive.
    assign w_hi_adj   = (r_scr[11:8] >= 4'd5) ? (r_scr[10:8] + 3'd3) : r_scr[10:8];
    assign w_scr_next = {w_hi_adj, w_lo_adj, r_src[7]};

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_capture)    w_next_state = c_CONV;
            c_CONV:  if (r_cnt == 3'd7) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_CONV);
    end

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 8'h00;
            r_src  <= 8'h00;
            r_scr  <= 12'h000;
            r_cnt  <= 3'd0;
            r_bcd  <= 12'h000;
        end else if (w_capture) begin
            r_last <= value;
            r_src  <= value;
            r_scr  <= 12'h000;
            r_cnt  <= 3'd0;
        end else if (r_state == c_CONV) begin
            r_scr <= w_scr_next;
            r_src <= {r_src[6:0], 1'b0};
            r_cnt <= r_cnt + 3'd1;
            if (w_last_shift) begin
                r_bcd <= w_scr_next;
            end
        end
    end

    assign bcd = r_bcd;

    // ------------------------------------------------------------------
    // Display refresh multiplexer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref <= '0;
            r_idx <= 2'd0;
        end else begin
            if (w_ref_wrap) begin
                r_ref <= '0;
                r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_ref <= r_ref + c_RW'(1);
            end
        end
    end

    always_comb begin
        w_digit = r_bcd[3:0];
        w_blank = 1'b0;
        an      = 3'b111;
        case (r_idx)
            2'd0: begin
                an      = 3'b110;
                w_digit = r_bcd[3:0];
            end
            2'd1: begin
                an      = 3'b101;
                w_digit = r_bcd[7:4];
                w_blank = BLANK_LEADING && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            end
            2'd2: begin
                an      = 3'b011;
                w_digit = r_bcd[11:8];
                w_blank = BLANK_LEADING && (r_bcd[11:8] == 4'd0);
            end
            default: begin
                an      = 3'b111;
                w_digit = r_bcd[3:0];
            end
        endcase
    end

    always_comb begin
        case (w_digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = c_SEG_DASH;
        endcase
        if (w_blank) begin
            seg = c_SEG_BLANK;
        end
    end

endmodule

`default_nettype wire
